alu: RTL and testbench
======================

Name: alu

Overview:
- 8-bit arithmetic/logic unit for the 6502-compatible cpu core; result and status flags are registered.
- cpu drives alu_a (normally A), alu_b (normally the data bus), mode and carry_in.
- carry_out, overflow, zero and sign feed processor status bits P[0], P[6], P[1] and P[7].
- Single clock domain; one-cycle latency from operands to result/flags.

Parameters:
WIDTH, 8, datapath width in bits; flags use bit WIDTH-1 as the sign bit.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
alu_a  input  WIDTH  operand A.
alu_b  input  WIDTH  operand B; ignored by SR.
mode  input  5  operation select: ADD=0, AND=1, OR=2, EOR=3, SR=4, SUB=5.
carry_in  input  1  carry into ADD, inverted borrow into SUB, fill bit for SR.
alu_out  output  WIDTH  registered result.
carry_out  output  1  registered carry flag.
overflow  output  1  registered signed-overflow flag.
zero  output  1  registered, 1 when alu_out is all zeros.
sign  output  1  registered, equals alu_out[WIDTH-1].

Behaviour:
- Reset: on a rising edge with reset=0, alu_out, carry_out, overflow, zero and sign all become 0.
  - This includes zero=0 even though alu_out=0.
  - Reset takes priority over any operation in the same cycle; an in-flight result is discarded.
- Latency: operands sampled at edge N appear on the outputs after edge N.
  - Outputs hold until the next edge.
  - A new operation may be issued every cycle; there is no handshake.
- Result and carry per mode (computed combinationally, then registered):
  - ADD: {carry_out, alu_out} = alu_a + alu_b + carry_in, computed to WIDTH+1 bits.
  - SUB: {carry_out, alu_out} = alu_a + ~alu_b + carry_in, WIDTH+1 bits. carry_out=1 means no borrow; with carry_in=1 this is a plain a-b.
  - AND / OR / EOR: bitwise alu_a & alu_b, alu_a | alu_b, alu_a ^ alu_b. carry_out = carry_in.
  - SR: alu_out = {carry_in, alu_a[WIDTH-1:1]}; carry_out = alu_a[0]. carry_in=0 gives a logical shift right; carry_in=1 gives a rotate-in of 1.
  - Modes 6..31 (undefined): alu_out = alu_a, carry_out = carry_in.
- Overflow flag:
  - ADD: 1 when alu_a and alu_b have the same sign bit and the result sign differs.
  - SUB: 1 when alu_a and alu_b have different sign bits and the result sign differs from alu_a.
  - All other modes: 0.
- zero and sign are derived from the result value being registered, so they are always consistent with alu_out. There is no stale-flag case.
- No internal state other than the output registers. Combinational path: inputs to register D only; no input-to-output combinational path.

Test Plan:
- Reset: hold reset=0 for 2 cycles while driving ADD 0xFF+0x01 -> all outputs 0. Release reset; one cycle later alu_out=0x00, C=1, Z=1, V=0, N=0.
- ADD: 0x50+0x50, cin=0 -> 0xA0, C=0, V=1, N=1, Z=0. 0x01+0x01, cin=1 -> 0x03, all flags 0.
- SUB:
  - 0x05-0x03, cin=1 -> 0x02, C=1, V=0.
  - 0x50-0xB0, cin=1 -> 0xA0, C=0, V=1, N=1.
  - 0x10-0x10, cin=0 -> 0xFF, C=0, N=1.
- Logic: with a=0xF0, b=0x3C, cin=1:
  - AND -> 0x30, C=1.
  - OR -> 0xFC, N=1.
  - EOR -> 0xCC.
  - AND of 0x0F with 0xF0 -> 0x00, Z=1, V=0.
- SR: 0x81, cin=0 -> 0x40, C=1, N=0. 0x81, cin=1 -> 0xC0, C=1, N=1. 0x01, cin=0 -> 0x00, Z=1, C=1.
- Back-to-back and undefined mode:
  - Issue ADD, SUB, SR on consecutive cycles; each result appears exactly one cycle after its inputs.
  - mode=7, a=0x5A, cin=1 -> 0x5A, C=1, V=0.
  - Assert reset mid-stream -> outputs 0 on the next edge.

Source files
------------

// File: rtl/alu.sv
// 8-bit ALU for the 6502-compatible core: ADD/SUB/logic/shift-right with
// registered result and C/V/Z/N flags, one cycle of latency.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       mode,
    input  logic             carry_in,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam logic [4:0] MODE_ADD = 5'd0;
    localparam logic [4:0] MODE_AND = 5'd1;
    localparam logic [4:0] MODE_OR  = 5'd2;
    localparam logic [4:0] MODE_EOR = 5'd3;
    localparam logic [4:0] MODE_SR  = 5'd4;
    localparam logic [4:0] MODE_SUB = 5'd5;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;

    assign sum_add = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, carry_in};
    assign sum_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        result_d   = alu_a;
        carry_d    = carry_in;
        overflow_d = 1'b0;
        case (mode)
            MODE_ADD: begin
                result_d   = sum_add[WIDTH-1:0];
                carry_d    = sum_add[WIDTH];
                overflow_d = (alu_a[MSB] == alu_b[MSB]) && (sum_add[MSB] != alu_a[MSB]);
            end
            MODE_SUB: begin
                // carry_d is the inverted borrow, as the 6502 expects
                result_d   = sum_sub[WIDTH-1:0];
                carry_d    = sum_sub[WIDTH];
                overflow_d = (alu_a[MSB] != alu_b[MSB]) && (sum_sub[MSB] != alu_a[MSB]);
            end
            MODE_AND: result_d = alu_a & alu_b;
            MODE_OR:  result_d = alu_a | alu_b;
            MODE_EOR: result_d = alu_a ^ alu_b;
            MODE_SR: begin
                result_d = {carry_in, alu_a[WIDTH-1:1]};
                carry_d  = alu_a[0];
            end
            default: begin
                result_d = alu_a;
                carry_d  = carry_in;
            end
        endcase
    end

    // zero/sign come from the value being registered so they never go stale
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            alu_out   <= result_d;
            carry_out <= carry_d;
            overflow  <= overflow_d;
            zero      <= (result_d == '0);
            sign      <= result_d[MSB];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expected results computed with
// plain integer arithmetic, a monitor pops and compares after each edge.
module tb_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] alu_a = '0;
    logic [7:0] alu_b = '0;
    logic [4:0] mode = '0;
    logic       carry_in = 1'b0;
    logic [7:0] alu_out;
    logic       carry_out, overflow, zero, sign;

    alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .mode(mode),
        .carry_in(carry_in), .alu_out(alu_out), .carry_out(carry_out),
        .overflow(overflow), .zero(zero), .sign(sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic       c, v, z, n;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   drive_done = 0;

    function automatic exp_t model(input int m, input int a, input int b, input int cin, input string tag);
        exp_t e;
        int   r, sa, sb, sr, cv;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        cv = cin;
        sr = 0;
        case (m)
            0: begin r = a + b + cin; cv = (r > 255); sr = sa + sb + cin; end
            5: begin r = a - b - (1 - cin); cv = (r >= 0); sr = sa - sb - (1 - cin); end
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4: begin r = cin * 128 + a / 2; cv = a % 2; end
            default: r = a;
        endcase
        r = r & 255;
        e.tag = tag;
        e.res = r[7:0];
        e.c   = (cv != 0);
        e.v   = (m == 0 || m == 5) && (sr > 127 || sr < -128);
        e.z   = (r == 0);
        e.n   = (r >= 128);
        return e;
    endfunction

    task automatic drive(input int m, input int a, input int b, input int cin, input bit rst_n, input string tag);
        exp_t e;
        @(negedge clk);
        mode     = m[4:0];
        alu_a    = a[7:0];
        alu_b    = b[7:0];
        carry_in = cin[0];
        reset    = rst_n;
        if (!rst_n) begin
            e.tag = tag; e.res = 8'h00; e.c = 0; e.v = 0; e.z = 0; e.n = 0;
        end else begin
            e = model(m, a, b, cin, tag);
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if ({alu_out, carry_out, overflow, zero, sign} === {e.res, e.c, e.v, e.z, e.n})
                    n_pass++;
                else
                    $display("FAIL %s: got out=%02h C=%0b V=%0b Z=%0b N=%0b, want out=%02h C=%0b V=%0b Z=%0b N=%0b",
                             e.tag, alu_out, carry_out, overflow, zero, sign,
                             e.res, e.c, e.v, e.z, e.n);
            end
        end
    end

    initial begin : driver
        int m, cin;
        bit rst_n;
        drive(0, 8'hFF, 8'h01, 0, 0, "reset_hold0");
        drive(0, 8'hFF, 8'h01, 0, 0, "reset_hold1");
        drive(0, 8'hFF, 8'h01, 0, 1, "reset_release_add");
        drive(0, 8'h50, 8'h50, 0, 1, "add_ovf");
        drive(0, 8'h01, 8'h01, 1, 1, "add_cin");
        drive(5, 8'h05, 8'h03, 1, 1, "sub_simple");
        drive(5, 8'h50, 8'hB0, 1, 1, "sub_ovf");
        drive(5, 8'h10, 8'h10, 0, 1, "sub_borrow");
        drive(1, 8'hF0, 8'h3C, 1, 1, "and");
        drive(2, 8'hF0, 8'h3C, 1, 1, "or");
        drive(3, 8'hF0, 8'h3C, 1, 1, "eor");
        drive(1, 8'h0F, 8'hF0, 1, 1, "and_zero");
        drive(4, 8'h81, 8'h00, 0, 1, "sr_lsr");
        drive(4, 8'h81, 8'h00, 1, 1, "sr_rot1");
        drive(4, 8'h01, 8'h00, 0, 1, "sr_zero");
        drive(0, 8'h7F, 8'h01, 0, 1, "b2b_add");
        drive(5, 8'h00, 8'h01, 1, 1, "b2b_sub");
        drive(4, 8'hFE, 8'h55, 1, 1, "b2b_sr");
        drive(7, 8'h5A, 8'hFF, 1, 1, "undef_mode7");
        drive(0, 8'h80, 8'h80, 1, 0, "reset_midstream");
        drive(31, 8'h00, 8'h12, 0, 1, "undef_mode31_zero");
        for (int i = 0; i < 400; i++) begin
            m     = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 31);
            cin   = $urandom_range(0, 1);
            rst_n = ($urandom_range(0, 39) != 0);
            drive(m, $urandom_range(0, 255), $urandom_range(0, 255), cin, rst_n, "random");
        end
        drive_done = 1;
    end

    initial begin : finisher
        int budget;
        wait (drive_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected results still pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
